// File: rtl/can_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : can_pkg
//  Purpose  : Shared types and constants for the CAN 2.0A receive sequencer:
//             field/state codes, fixed field lengths, CRC-15 polynomial,
//             error codes and a single-bit CRC-15 update helper.
//  Revision : 1.0  initial release
// ============================================================================
package can_pkg;

   // Field the receiver is currently expecting; also exported as the state code
   typedef enum logic [3:0] {
      WAIT_IDLE = 4'd0,
      IDLE      = 4'd1,
      ID        = 4'd2,
      RTR       = 4'd3,
      IDE       = 4'd4,
      R0        = 4'd5,
      DLC       = 4'd6,
      DATA      = 4'd7,
      CRC       = 4'd8,
      CRC_DEL   = 4'd9,
      ACK       = 4'd10,
      ACK_DEL   = 4'd11,
      EOF       = 4'd12,
      IFS       = 4'd13
   } field_t;

   // Fixed field lengths in bits
   localparam int LEN_ID  = 11;
   localparam int LEN_DLC = 4;
   localparam int LEN_CRC = 15;
   localparam int LEN_EOF = 7;
   localparam int LEN_IFS = 3;

   localparam logic [14:0] CRC15_POLY = 15'h4599;

   // Error codes reported with the err pulse
   localparam logic [2:0] ERR_NONE  = 3'd0;
   localparam logic [2:0] ERR_STUFF = 3'd1;
   localparam logic [2:0] ERR_FORM  = 3'd2;
   localparam logic [2:0] ERR_CRC   = 3'd3;
   localparam logic [2:0] ERR_EXT   = 3'd4;

   // One CRC-15 step: feedback is the incoming bit XOR the register MSB
   function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic b);
      logic fb;
      fb = b ^ crc[14];
      return {crc[13:0], 1'b0} ^ (fb ? CRC15_POLY : 15'h0000);
   endfunction

endpackage
`default_nettype wire

// File: rtl/can_crc15.sv
`default_nettype none
// ============================================================================
//  Module   : can_crc15
//  Purpose  : CRC-15 (CAN) accumulation register, one bit per shift_en.
//             clr has priority over shift_en.
//  Revision : 1.0  initial release
// ============================================================================
module can_crc15
   import can_pkg::*;
(
   input  logic        clkin,
   input  logic        rst,
   input  logic        clr,
   input  logic        shift_en,
   input  logic        bit_in,
   output logic [14:0] crc
);

   logic [14:0] r_crc;

   // Clear on reset/SOF, otherwise fold in one destuffed bit per enable
   always_ff @(posedge clkin) begin
      if (rst || clr) begin
         r_crc <= 15'h0000;
      end else if (shift_en) begin
         r_crc <= crc15_step(r_crc, bit_in);
      end
   end

   assign crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/can_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : can_frame_sequencer
//  Purpose  : Receive-side CAN 2.0A base-frame field sequencer. Walks the
//             frame field by field, gates the unstuffer, extracts the
//             frame contents, checks CRC-15 and form, and reports completion
//             or abort.
//  Revision : 1.0  initial release
// ============================================================================
module can_frame_sequencer
   import can_pkg::*;
#(
   parameter int IDLE_BITS = 11,
   parameter int MAX_BYTES = 8
) (
   input  logic        clkin,
   input  logic        rst,
   input  logic        bit_valid,
   input  logic        bit_in,
   input  logic        stuff_err,
   output logic        unstuff_en,
   output logic [3:0]  field,
   output logic [10:0] frame_id,
   output logic        frame_rtr,
   output logic [3:0]  frame_dlc,
   output logic [7:0]  data_byte,
   output logic        data_valid,
   output logic [14:0] crc_rx,
   output logic        ack_seen,
   output logic        frame_ok,
   output logic        err,
   output logic [2:0]  err_code,
   output logic        bus_idle
);

   localparam logic [6:0] c_IDLE_LAST = 7'(IDLE_BITS - 1);
   localparam logic [6:0] c_ID_LAST   = 7'(LEN_ID - 1);
   localparam logic [6:0] c_DLC_LAST  = 7'(LEN_DLC - 1);
   localparam logic [6:0] c_CRC_LAST  = 7'(LEN_CRC - 1);
   localparam logic [6:0] c_EOF_LAST  = 7'(LEN_EOF - 1);
   localparam logic [6:0] c_IFS_LAST  = 7'(LEN_IFS - 1);
   localparam logic [3:0] c_MAX_BYTES = 4'(MAX_BYTES);

   field_t      r_field;
   logic [6:0]  r_bit_cnt;
   logic [6:0]  r_data_bits;
   logic        r_unstuff_en;
   logic [10:0] r_id;
   logic        r_rtr;
   logic [3:0]  r_dlc;
   logic [6:0]  r_shift;
   logic [7:0]  r_data_byte;
   logic        r_data_valid;
   logic [14:0] r_crc_rx;
   logic        r_ack_seen;
   logic        r_frame_ok;
   logic        r_err;
   logic [2:0]  r_err_code;
   logic        r_bus_idle;

   logic [14:0] w_crc;
   logic        w_stuff_hit;
   logic        w_crc_clr;
   logic        w_crc_shift;
   logic        w_err_hit;
   logic [2:0]  w_err_sel;
   logic [3:0]  w_dlc_shift;
   logic [3:0]  w_bytes;
   logic [6:0]  w_data_bits;

   // A stuff violation only counts while the unstuffer is enabled
   assign w_stuff_hit = bit_valid && r_unstuff_en && stuff_err;

   // SOF clears the CRC; SOF itself is a 0 into a zero register, so no shift needed
   assign w_crc_clr   = bit_valid && (r_field == IDLE) && !bit_in;
   assign w_crc_shift = bit_valid && !w_stuff_hit &&
                        (r_field inside {ID, RTR, IDE, R0, DLC, DATA});

   // Payload length decided on the last DLC bit; RTR frames carry no data
   assign w_dlc_shift = {r_dlc[2:0], bit_in};
   assign w_bytes     = r_rtr ? 4'd0 :
                        ((w_dlc_shift > c_MAX_BYTES) ? c_MAX_BYTES : w_dlc_shift);
   assign w_data_bits = {w_bytes, 3'b000};

   can_crc15 u_crc (
      .clkin    (clkin),
      .rst      (rst),
      .clr      (w_crc_clr),
      .shift_en (w_crc_shift),
      .bit_in   (bit_in),
      .crc      (w_crc)
   );

   // Error detection for the bit currently offered; stuff errors take precedence
   always_comb begin
      w_err_hit = 1'b0;
      w_err_sel = ERR_NONE;
      if (w_stuff_hit) begin
         w_err_hit = 1'b1;
         w_err_sel = ERR_STUFF;
      end else if (bit_valid) begin
         case (r_field)
            IDE: begin
               if (bit_in) begin
                  w_err_hit = 1'b1;
                  w_err_sel = ERR_EXT;
               end
            end
            CRC_DEL: begin
               if (!bit_in) begin
                  w_err_hit = 1'b1;
                  w_err_sel = ERR_FORM;
               end else if (r_crc_rx != w_crc) begin
                  w_err_hit = 1'b1;
                  w_err_sel = ERR_CRC;
               end
            end
            ACK_DEL: begin
               if (!bit_in) begin
                  w_err_hit = 1'b1;
                  w_err_sel = ERR_FORM;
               end
            end
            EOF: begin
               // A dominant last EOF bit is an overload indication, not an error
               if (!bit_in && (r_bit_cnt != c_EOF_LAST)) begin
                  w_err_hit = 1'b1;
                  w_err_sel = ERR_FORM;
               end
            end
            default: ;
         endcase
      end
   end

   // Field sequencer: advances one step per valid bit, pulses clear every cycle
   always_ff @(posedge clkin) begin
      if (rst) begin
         r_field      <= WAIT_IDLE;
         r_bit_cnt    <= 7'd0;
         r_data_bits  <= 7'd0;
         r_unstuff_en <= 1'b0;
         r_id         <= 11'd0;
         r_rtr        <= 1'b0;
         r_dlc        <= 4'd0;
         r_shift      <= 7'd0;
         r_data_byte  <= 8'd0;
         r_data_valid <= 1'b0;
         r_crc_rx     <= 15'd0;
         r_ack_seen   <= 1'b0;
         r_frame_ok   <= 1'b0;
         r_err        <= 1'b0;
         r_err_code   <= ERR_NONE;
         r_bus_idle   <= 1'b0;
      end else begin
         r_data_valid <= 1'b0;
         r_frame_ok   <= 1'b0;
         r_err        <= 1'b0;
         if (bit_valid) begin
            if (w_err_hit) begin
               // Abort: partial fields stay as received, the offending bit is dropped
               r_err        <= 1'b1;
               r_err_code   <= w_err_sel;
               r_unstuff_en <= 1'b0;
               r_field      <= WAIT_IDLE;
               r_bit_cnt    <= 7'd0;
               r_bus_idle   <= 1'b0;
            end else begin
               case (r_field)
                  WAIT_IDLE: begin
                     if (!bit_in) begin
                        r_bit_cnt <= 7'd0;
                     end else if (r_bit_cnt == c_IDLE_LAST) begin
                        r_bit_cnt  <= 7'd0;
                        r_field    <= IDLE;
                        r_bus_idle <= 1'b1;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 7'd1;
                     end
                  end
                  IDLE: begin
                     if (!bit_in) begin
                        r_field      <= ID;
                        r_bus_idle   <= 1'b0;
                        r_bit_cnt    <= 7'd0;
                        r_ack_seen   <= 1'b0;
                        r_err_code   <= ERR_NONE;
                        r_unstuff_en <= 1'b1;
                     end
                  end
                  ID: begin
                     r_id <= {r_id[9:0], bit_in};
                     if (r_bit_cnt == c_ID_LAST) begin
                        r_bit_cnt <= 7'd0;
                        r_field   <= RTR;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 7'd1;
                     end
                  end
                  RTR: begin
                     r_rtr   <= bit_in;
                     r_field <= IDE;
                  end
                  IDE: r_field <= R0;
                  R0: begin
                     r_bit_cnt <= 7'd0;
                     r_field   <= DLC;
                  end
                  DLC: begin
                     r_dlc <= w_dlc_shift;
                     if (r_bit_cnt == c_DLC_LAST) begin
                        r_bit_cnt   <= 7'd0;
                        r_data_bits <= w_data_bits;
                        r_field     <= (w_bytes == 4'd0) ? CRC : DATA;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 7'd1;
                     end
                  end
                  DATA: begin
                     r_shift <= {r_shift[5:0], bit_in};
                     if (r_bit_cnt[2:0] == 3'd7) begin
                        r_data_byte  <= {r_shift, bit_in};
                        r_data_valid <= 1'b1;
                     end
                     if (r_bit_cnt == r_data_bits - 7'd1) begin
                        r_bit_cnt <= 7'd0;
                        r_field   <= CRC;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 7'd1;
                     end
                  end
                  CRC: begin
                     r_crc_rx <= {r_crc_rx[13:0], bit_in};
                     if (r_bit_cnt == c_CRC_LAST) begin
                        r_bit_cnt    <= 7'd0;
                        r_unstuff_en <= 1'b0;
                        r_field      <= CRC_DEL;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 7'd1;
                     end
                  end
                  CRC_DEL: r_field <= ACK;
                  ACK: begin
                     if (!bit_in) begin
                        r_ack_seen <= 1'b1;
                     end
                     r_field <= ACK_DEL;
                  end
                  ACK_DEL: begin
                     r_bit_cnt <= 7'd0;
                     r_field   <= EOF;
                  end
                  EOF: begin
                     if (r_bit_cnt == c_EOF_LAST) begin
                        r_bit_cnt  <= 7'd0;
                        r_frame_ok <= 1'b1;
                        r_field    <= bit_in ? IFS : WAIT_IDLE;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 7'd1;
                     end
                  end
                  IFS: begin
                     if (!bit_in) begin
                        r_bit_cnt <= 7'd0;
                        r_field   <= WAIT_IDLE;
                     end else if (r_bit_cnt == c_IFS_LAST) begin
                        r_bit_cnt  <= 7'd0;
                        r_field    <= IDLE;
                        r_bus_idle <= 1'b1;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 7'd1;
                     end
                  end
                  default: begin
                     r_bit_cnt <= 7'd0;
                     r_field   <= WAIT_IDLE;
                  end
               endcase
            end
         end
      end
   end

   assign unstuff_en = r_unstuff_en;
   assign field      = r_field;
   assign frame_id   = r_id;
   assign frame_rtr  = r_rtr;
   assign frame_dlc  = r_dlc;
   assign data_byte  = r_data_byte;
   assign data_valid = r_data_valid;
   assign crc_rx     = r_crc_rx;
   assign ack_seen   = r_ack_seen;
   assign frame_ok   = r_frame_ok;
   assign err        = r_err;
   assign err_code   = r_err_code;
   assign bus_idle   = r_bus_idle;

endmodule
`default_nettype wire

// File: tb/tb_can_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_can_frame_sequencer
//  Purpose  : Self-checking bench for can_frame_sequencer. Frames are built
//             as bit lists from field values, CRC-15 is computed over the
//             list, and observed pulses are collected and compared.
//  Revision : 1.0  initial release
// ============================================================================
module tb_can_frame_sequencer;
   import can_pkg::*;

   logic        clkin = 1'b0;
   logic        rst = 1'b1;
   logic        bit_valid = 1'b0;
   logic        bit_in = 1'b1;
   logic        stuff_err = 1'b0;
   logic        unstuff_en;
   logic [3:0]  field;
   logic [10:0] frame_id;
   logic        frame_rtr;
   logic [3:0]  frame_dlc;
   logic [7:0]  data_byte;
   logic        data_valid;
   logic [14:0] crc_rx;
   logic        ack_seen;
   logic        frame_ok;
   logic        err;
   logic [2:0]  err_code;
   logic        bus_idle;

   can_frame_sequencer #(.IDLE_BITS(11), .MAX_BYTES(8)) dut (
      .clkin(clkin), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in),
      .stuff_err(stuff_err), .unstuff_en(unstuff_en), .field(field),
      .frame_id(frame_id), .frame_rtr(frame_rtr), .frame_dlc(frame_dlc),
      .data_byte(data_byte), .data_valid(data_valid), .crc_rx(crc_rx),
      .ack_seen(ack_seen), .frame_ok(frame_ok), .err(err),
      .err_code(err_code), .bus_idle(bus_idle)
   );

   always #5 clkin = ~clkin;

   int checks = 0;
   int failures = 0;

   // Pulse monitor, sampled mid-cycle
   logic [7:0] dv_q[$];
   int         ok_cnt = 0;
   int         err_cnt = 0;
   int         both_cnt = 0;
   logic [2:0] last_code = 3'd0;

   always @(negedge clkin) begin
      if (data_valid) dv_q.push_back(data_byte);
      if (frame_ok) ok_cnt++;
      if (err) begin
         err_cnt++;
         last_code = err_code;
      end
      if (frame_ok && err) both_cnt++;
   end

   // Reference frame as a destuffed bit list
   logic       fr[$];
   logic [7:0] d_bytes[8];
   int         nbytes;
   logic [14:0] exp_crc;
   int         ue_bad;

   function automatic logic [14:0] model_crc(input int n);
      logic [14:0] c;
      logic nxt;
      c = 15'h0000;
      for (int i = 0; i < n; i++) begin
         nxt = fr[i] ^ c[14];
         c = {c[13:0], 1'b0};
         if (nxt) c = c ^ 15'h4599;
      end
      return c;
   endfunction

   task automatic build_frame(input logic [10:0] id, input logic rtr, input logic ide,
                              input logic [3:0] dlc, input logic ack);
      fr.delete();
      fr.push_back(1'b0);
      for (int i = 10; i >= 0; i--) fr.push_back(id[i]);
      fr.push_back(rtr);
      fr.push_back(ide);
      fr.push_back(1'b0);
      for (int i = 3; i >= 0; i--) fr.push_back(dlc[i]);
      if (rtr) nbytes = 0;
      else if (dlc > 4'd8) nbytes = 8;
      else nbytes = int'(dlc);
      for (int k = 0; k < nbytes; k++)
         for (int b = 7; b >= 0; b--) fr.push_back(d_bytes[k][b]);
      exp_crc = model_crc(fr.size());
      for (int i = 14; i >= 0; i--) fr.push_back(exp_crc[i]);
      fr.push_back(1'b1);
      fr.push_back(ack);
      fr.push_back(1'b1);
      for (int i = 0; i < 7 + 3; i++) fr.push_back(1'b1);
   endtask

   function automatic int crc_last_idx();  return 33 + 8 * nbytes; endfunction
   function automatic int eof_first_idx(); return 37 + 8 * nbytes; endfunction

   task automatic clear_mon();
      dv_q.delete();
      ok_cnt = 0;
      err_cnt = 0;
      last_code = 3'd0;
      ue_bad = 0;
   endtask

   // One bit: strobe for one cycle, then one quiet cycle
   task automatic send_bit(input logic b, input logic exp_ue, input logic chk);
      bit_valid = 1'b1;
      bit_in = b;
      if (chk && (unstuff_en !== exp_ue)) ue_bad++;
      @(posedge clkin); #1;
      bit_valid = 1'b0;
      bit_in = 1'b1;
      @(posedge clkin); #1;
   endtask

   task automatic send_range(input int lo, input int hi, input logic chk);
      for (int i = lo; i <= hi; i++)
         send_bit(fr[i], (i >= 1) && (i <= crc_last_idx()), chk);
   endtask

   task automatic go_idle();
      for (int i = 0; i < 11; i++) send_bit(1'b1, 1'b0, 1'b0);
      checks++;
      if (bus_idle !== 1'b1 || field !== 4'(IDLE)) begin
         failures++;
         $display("FAIL go_idle: bus_idle=%0b field=%0d expected bus_idle=1 field=%0d",
                  bus_idle, field, 4'(IDLE));
      end
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if ({unstuff_en, field, frame_id, frame_rtr, frame_dlc, data_byte, data_valid,
           crc_rx, ack_seen, frame_ok, err, err_code, bus_idle} !== '0) begin
         failures++;
         $display("FAIL %s: outputs not all zero (field=%0d id=%0h dlc=%0h byte=%0h crc=%0h ue=%0b ack=%0b idle=%0b) expected 0",
                  name, field, frame_id, frame_dlc, data_byte, crc_rx, unstuff_en, ack_seen, bus_idle);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clkin);
      #1;
      check_all_zero("reset_outputs");
      rst = 1'b0;
      @(posedge clkin); #1;
      clear_mon();
   endtask

   task automatic test_no_idle();
      clear_mon();
      d_bytes[0] = 8'hA5;
      d_bytes[1] = 8'h5A;
      build_frame(11'h123, 1'b0, 1'b0, 4'd2, 1'b0);
      send_range(0, eof_first_idx() + 6, 1'b0);
      checks++;
      if (dv_q.size() != 0 || ok_cnt != 0 || bus_idle !== 1'b0) begin
         failures++;
         $display("FAIL no_idle: data=%0d ok=%0d idle=%0b expected 0 0 0",
                  dv_q.size(), ok_cnt, bus_idle);
      end
      go_idle();
   endtask

   task automatic test_basic();
      clear_mon();
      d_bytes[0] = 8'hA5;
      d_bytes[1] = 8'h5A;
      build_frame(11'h123, 1'b0, 1'b0, 4'd2, 1'b0);
      send_range(0, fr.size() - 1, 1'b1);
      checks++;
      if (dv_q.size() != 2) begin
         failures++;
         $display("FAIL basic_data_count: got %0d expected 2", dv_q.size());
      end else if (dv_q[0] !== 8'hA5 || dv_q[1] !== 8'h5A) begin
         failures++;
         $display("FAIL basic_data: got %0h %0h expected a5 5a", dv_q[0], dv_q[1]);
      end
      checks++;
      if (ok_cnt != 1 || err_cnt != 0) begin
         failures++;
         $display("FAIL basic_ok: ok=%0d err=%0d expected 1 0", ok_cnt, err_cnt);
      end
      checks++;
      if (ack_seen !== 1'b1 || frame_id !== 11'h123 || frame_dlc !== 4'd2 || frame_rtr !== 1'b0) begin
         failures++;
         $display("FAIL basic_fields: ack=%0b id=%0h dlc=%0d rtr=%0b expected 1 123 2 0",
                  ack_seen, frame_id, frame_dlc, frame_rtr);
      end
      checks++;
      if (crc_rx !== exp_crc) begin
         failures++;
         $display("FAIL basic_crc_rx: got %0h expected %0h", crc_rx, exp_crc);
      end
      checks++;
      if (ue_bad != 0) begin
         failures++;
         $display("FAIL basic_unstuff_en: %0d bits wrong expected 0", ue_bad);
      end
      checks++;
      if (bus_idle !== 1'b1) begin
         failures++;
         $display("FAIL basic_ifs_idle: got %0b expected 1", bus_idle);
      end
   endtask

   task automatic test_crc_err();
      clear_mon();
      d_bytes[0] = 8'hA5;
      d_bytes[1] = 8'h5A;
      build_frame(11'h123, 1'b0, 1'b0, 4'd2, 1'b0);
      fr[crc_last_idx()] = ~fr[crc_last_idx()];
      send_range(0, crc_last_idx(), 1'b0);
      checks++;
      if (err_cnt != 0) begin
         failures++;
         $display("FAIL crc_err_early: err=%0d expected 0 before delimiter", err_cnt);
      end
      send_range(crc_last_idx() + 1, fr.size() - 1, 1'b0);
      checks++;
      if (err_cnt != 1 || last_code !== ERR_CRC || ok_cnt != 0) begin
         failures++;
         $display("FAIL crc_err: err=%0d code=%0d ok=%0d expected 1 3 0", err_cnt, last_code, ok_cnt);
      end
      go_idle();
   endtask

   task automatic test_stuff_err();
      clear_mon();
      d_bytes[0] = 8'($urandom);
      build_frame(11'($urandom), 1'b0, 1'b0, 4'd1, 1'b0);
      send_range(0, 22, 1'b0);
      bit_valid = 1'b1;
      bit_in = fr[23];
      stuff_err = 1'b1;
      @(posedge clkin); #1;
      bit_valid = 1'b0;
      stuff_err = 1'b0;
      checks++;
      if (err !== 1'b1 || err_code !== ERR_STUFF || unstuff_en !== 1'b0 || field !== 4'(WAIT_IDLE)) begin
         failures++;
         $display("FAIL stuff_err: err=%0b code=%0d ue=%0b field=%0d expected 1 1 0 0",
                  err, err_code, unstuff_en, field);
      end
      @(posedge clkin); #1;
      checks++;
      if (dv_q.size() != 0 || err_cnt != 1) begin
         failures++;
         $display("FAIL stuff_err_pulse: data=%0d err=%0d expected 0 1", dv_q.size(), err_cnt);
      end
      go_idle();
   endtask

   task automatic test_len(input logic rtr, input logic [3:0] dlc, input int exp_n, input string name);
      clear_mon();
      for (int k = 0; k < 8; k++) d_bytes[k] = 8'($urandom);
      build_frame(11'($urandom), rtr, 1'b0, dlc, 1'b0);
      send_range(0, fr.size() - 1, 1'b1);
      checks++;
      if (dv_q.size() != exp_n || ok_cnt != 1 || err_cnt != 0 || ue_bad != 0 || crc_rx !== exp_crc) begin
         failures++;
         $display("FAIL %s: data=%0d ok=%0d err=%0d ue_bad=%0d crc=%0h expected %0d 1 0 0 %0h",
                  name, dv_q.size(), ok_cnt, err_cnt, ue_bad, crc_rx, exp_n, exp_crc);
      end
   endtask

   task automatic test_err_at(input int idx, input logic [2:0] code, input string name);
      clear_mon();
      send_range(0, idx, 1'b0);
      checks++;
      if (err_cnt != 1 || last_code !== code || ok_cnt != 0 || field !== 4'(WAIT_IDLE)) begin
         failures++;
         $display("FAIL %s: err=%0d code=%0d ok=%0d field=%0d expected 1 %0d 0 0",
                  name, err_cnt, last_code, ok_cnt, field, code);
      end
      go_idle();
   endtask

   task automatic test_errors();
      build_frame(11'h2AA, 1'b0, 1'b1, 4'd0, 1'b0);
      test_err_at(13, ERR_EXT, "ide_err");
      d_bytes[0] = 8'h3C;
      build_frame(11'h055, 1'b0, 1'b0, 4'd1, 1'b0);
      fr[eof_first_idx() + 2] = 1'b0;
      test_err_at(eof_first_idx() + 2, ERR_FORM, "eof3_err");
      build_frame(11'h055, 1'b0, 1'b0, 4'd1, 1'b0);
      fr[crc_last_idx() + 1] = 1'b0;
      test_err_at(crc_last_idx() + 1, ERR_FORM, "crc_del_err");
   endtask

   task automatic test_eof7();
      clear_mon();
      d_bytes[0] = 8'h81;
      build_frame(11'h7F0, 1'b0, 1'b0, 4'd1, 1'b0);
      fr[eof_first_idx() + 6] = 1'b0;
      send_range(0, eof_first_idx() + 6, 1'b0);
      checks++;
      if (ok_cnt != 1 || err_cnt != 0 || field !== 4'(WAIT_IDLE) || dv_q.size() != 1) begin
         failures++;
         $display("FAIL eof7_overload: ok=%0d err=%0d field=%0d data=%0d expected 1 0 0 1",
                  ok_cnt, err_cnt, field, dv_q.size());
      end
      go_idle();
   endtask

   task automatic test_rst_mid();
      clear_mon();
      for (int k = 0; k < 8; k++) d_bytes[k] = 8'($urandom);
      build_frame(11'h3FF, 1'b0, 1'b0, 4'd4, 1'b0);
      send_range(0, 35, 1'b0);
      rst = 1'b1;
      @(posedge clkin); #1;
      rst = 1'b0;
      check_all_zero("rst_mid_outputs");
      @(posedge clkin); #1;
      checks++;
      if (err_cnt != 0) begin
         failures++;
         $display("FAIL rst_mid_no_err: err=%0d expected 0", err_cnt);
      end
      go_idle();
   endtask

   task automatic test_random();
      logic [10:0] id;
      logic        rtr, ack;
      logic [3:0]  dlc;
      int          fault, bad;
      for (int n = 0; n < 20; n++) begin
         clear_mon();
         id = 11'($urandom);
         rtr = ($urandom_range(0, 3) == 0);
         dlc = 4'($urandom);
         ack = 1'($urandom);
         fault = $urandom_range(0, 1);
         for (int k = 0; k < 8; k++) d_bytes[k] = 8'($urandom);
         build_frame(id, rtr, 1'b0, dlc, ack);
         if (fault == 1) begin
            int p;
            p = crc_last_idx() - $urandom_range(0, 14);
            fr[p] = ~fr[p];
         end
         send_range(0, fr.size() - 1, (fault == 0));
         bad = 0;
         if (dv_q.size() != nbytes) bad++;
         else for (int k = 0; k < nbytes; k++) if (dv_q[k] !== d_bytes[k]) bad++;
         checks++;
         if (bad != 0) begin
            failures++;
            $display("FAIL rand_data[%0d]: %0d byte errors, got %0d bytes expected %0d",
                     n, bad, dv_q.size(), nbytes);
         end
         checks++;
         if (fault == 0) begin
            if (ok_cnt != 1 || err_cnt != 0 || ack_seen !== ~ack || frame_id !== id ||
                frame_dlc !== dlc || frame_rtr !== rtr || ue_bad != 0) begin
               failures++;
               $display("FAIL rand_ok[%0d]: ok=%0d err=%0d ack_seen=%0b id=%0h dlc=%0d rtr=%0b ue_bad=%0d expected 1 0 %0b %0h %0d %0b 0",
                        n, ok_cnt, err_cnt, ack_seen, frame_id, frame_dlc, frame_rtr, ue_bad, ~ack, id, dlc, rtr);
            end
         end else begin
            if (ok_cnt != 0 || err_cnt != 1 || last_code !== ERR_CRC) begin
               failures++;
               $display("FAIL rand_crc[%0d]: ok=%0d err=%0d code=%0d expected 0 1 3",
                        n, ok_cnt, err_cnt, last_code);
            end
            go_idle();
         end
      end
   endtask

   initial begin
      test_reset();
      test_no_idle();
      test_basic();
      test_crc_err();
      test_stuff_err();
      test_len(1'b0, 4'd15, 8, "dlc15_cap");
      test_len(1'b1, 4'd3, 0, "rtr_dlc3");
      test_errors();
      test_eof7();
      test_rst_mid();
      test_random();
      checks++;
      if (both_cnt != 0) begin
         failures++;
         $display("FAIL ok_err_exclusive: got %0d overlaps expected 0", both_cnt);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
